// File: rtl/ula_wb_pkg.sv
// Shared definitions for the ula write-back stage: default sizes and FSM states.
// The optional bypass is controlled by the ULA_WB_FORWARD_EN macro in ula_wb.sv.
package ula_wb_pkg;

    localparam int WB_BITS = 8;
    localparam int WB_REGS = 4;
    localparam int WB_ADDR = 2;

    typedef enum logic {
        WB_CLEAR = 1'b0,
        WB_RUN   = 1'b1
    } wb_state_t;

endpackage

// File: rtl/ula_wb_if.sv
// Write-back bus between the execute side (master) and the ula_wb stage (slave).
// Carries the write handshake, both read ports and the status flags.
interface ula_wb_if
    import ula_wb_pkg::*;
#(
    parameter int BITS = WB_BITS,
    parameter int ADDR = WB_ADDR
);

    logic            wr_valid_in;
    logic            wr_ready_out;
    logic [ADDR-1:0] wr_addr_in;
    logic [BITS-1:0] wr_data_in;
    logic [ADDR-1:0] ra_addr_in;
    logic [ADDR-1:0] rb_addr_in;
    logic [BITS-1:0] a_out;
    logic [BITS-1:0] b_out;
    logic            zero_out;
    logic            neg_out;

    modport master (
        output wr_valid_in,
        output wr_addr_in,
        output wr_data_in,
        output ra_addr_in,
        output rb_addr_in,
        input  wr_ready_out,
        input  a_out,
        input  b_out,
        input  zero_out,
        input  neg_out
    );

    modport slave (
        input  wr_valid_in,
        input  wr_addr_in,
        input  wr_data_in,
        input  ra_addr_in,
        input  rb_addr_in,
        output wr_ready_out,
        output a_out,
        output b_out,
        output zero_out,
        output neg_out
    );

endinterface

// File: rtl/ula_wb_reg_bank.sv
// Register storage for the write-back stage: one synchronous write port and
// two combinational read ports. Contents are initialised by the owner's clear sequence.
module ula_wb_reg_bank
    import ula_wb_pkg::*;
#(
    parameter int BITS = WB_BITS,
    parameter int REGS = WB_REGS,
    parameter int ADDR = WB_ADDR
) (
    input  logic            clk_in,
    input  logic            we,
    input  logic [ADDR-1:0] waddr,
    input  logic [BITS-1:0] wdata,
    input  logic [ADDR-1:0] raddr_a,
    input  logic [ADDR-1:0] raddr_b,
    output logic [BITS-1:0] rdata_a,
    output logic [BITS-1:0] rdata_b
);

    logic [BITS-1:0] mem [REGS];

    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/ula_wb.sv
// Write-back stage for the ula: clear-on-reset register bank, write handshake,
// zero/negative flags and operand read ports. Optional bypass: ULA_WB_FORWARD_EN.
module ula_wb
    import ula_wb_pkg::*;
#(
    parameter int BITS = WB_BITS,
    parameter int REGS = WB_REGS,
    parameter int ADDR = WB_ADDR
) (
    input  logic     clk_in,
    input  logic     rst_in,
    ula_wb_if.slave  bus
);

    localparam logic [ADDR-1:0] LAST_REG = ADDR'(REGS - 1);

    wb_state_t       state;
    wb_state_t       next_state;
    logic [ADDR-1:0] clear_cnt;
    logic            ready;
    logic            wr_fire;
    logic            zero_q;
    logic            neg_q;

    logic            bank_we;
    logic [ADDR-1:0] bank_waddr;
    logic [BITS-1:0] bank_wdata;
    logic [BITS-1:0] bank_a;
    logic [BITS-1:0] bank_b;
    logic            fwd_a;
    logic            fwd_b;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= WB_CLEAR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        case (state)
            WB_CLEAR: begin
                if (clear_cnt == LAST_REG) begin
                    next_state = WB_RUN;
                end
            end
            WB_RUN: begin
                ready = 1'b1;
            end
            default: begin
                next_state = WB_CLEAR;
            end
        endcase
    end

    // A write presented while reset is sampled is dropped, even if we were in RUN.
    assign wr_fire = bus.wr_valid_in && ready && !rst_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            clear_cnt <= '0;
        end else if (state == WB_CLEAR) begin
            clear_cnt <= clear_cnt + ADDR'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (wr_fire) begin
            zero_q <= (bus.wr_data_in == '0);
            neg_q  <= bus.wr_data_in[BITS-1];
        end
    end

    always_comb begin
        bank_we    = 1'b0;
        bank_waddr = bus.wr_addr_in;
        bank_wdata = bus.wr_data_in;
        if (!rst_in) begin
            if (state == WB_CLEAR) begin
                bank_we    = 1'b1;
                bank_waddr = clear_cnt;
                bank_wdata = '0;
            end else if (wr_fire) begin
                bank_we = 1'b1;
            end
        end
    end

    ula_wb_reg_bank #(
        .BITS (BITS),
        .REGS (REGS),
        .ADDR (ADDR)
    ) u_bank (
        .clk_in  (clk_in),
        .we      (bank_we),
        .waddr   (bank_waddr),
        .wdata   (bank_wdata),
        .raddr_a (bus.ra_addr_in),
        .raddr_b (bus.rb_addr_in),
        .rdata_a (bank_a),
        .rdata_b (bank_b)
    );

`ifdef ULA_WB_FORWARD_EN
    // Bypass follows the handshake itself; ready already implies RUN.
    assign fwd_a = bus.wr_valid_in && ready && (bus.wr_addr_in == bus.ra_addr_in);
    assign fwd_b = bus.wr_valid_in && ready && (bus.wr_addr_in == bus.rb_addr_in);
`else
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
`endif

    always_comb begin
        bus.a_out = '0;
        bus.b_out = '0;
        if (state == WB_RUN) begin
            bus.a_out = fwd_a ? bus.wr_data_in : bank_a;
            bus.b_out = fwd_b ? bus.wr_data_in : bank_b;
        end
    end

    assign bus.wr_ready_out = ready;
    assign bus.zero_out     = zero_q;
    assign bus.neg_out      = neg_q;

endmodule

// File: tb/tb_ula_wb.sv
// Self-checking bench for ula_wb: directed test-plan sequences plus randomized
// traffic, all compared every cycle against a cycle-count based reference model.
module tb_ula_wb;

    localparam int BITS = 8;
    localparam int REGS = 4;
    localparam int ADDR = 2;

    logic clk_in;
    logic rst_in;

    ula_wb_if #(.BITS(BITS), .ADDR(ADDR)) bus ();

    ula_wb #(.BITS(BITS), .REGS(REGS), .ADDR(ADDR)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    int nChecks = 0;
    int nFail   = 0;

    // Reference state: registers, flags and how many clear cycles have elapsed.
    logic [BITS-1:0] modelReg [REGS];
    logic            modelZero;
    logic            modelNeg;
    int              clearCount;
    bit              modelValid = 0;

`ifdef ULA_WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic valid, input logic [ADDR-1:0] waddr,
                                 input logic [BITS-1:0] wdata, input logic [ADDR-1:0] ra,
                                 input logic [ADDR-1:0] rb);
        @(posedge clk_in);
        #1;
        rst_in          = rst;
        bus.wr_valid_in = valid;
        bus.wr_addr_in  = waddr;
        bus.wr_data_in  = wdata;
        bus.ra_addr_in  = ra;
        bus.rb_addr_in  = rb;
    endtask

    task automatic settle();
        @(negedge clk_in);
        #1;
    endtask

    // Model update: reset restarts the clear count; REGS clear cycles must pass before writes land.
    always @(posedge clk_in) begin
        if (rst_in) begin
            clearCount = 0;
            modelZero  = 1'b0;
            modelNeg   = 1'b0;
            for (int i = 0; i < REGS; i++) modelReg[i] = '0;
            modelValid = 1;
        end else if (clearCount < REGS) begin
            clearCount++;
        end else if (bus.wr_valid_in) begin
            modelReg[bus.wr_addr_in] = bus.wr_data_in;
            modelZero = (bus.wr_data_in == 0);
            modelNeg  = bus.wr_data_in[BITS-1];
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk_in) begin
        if (modelValid) begin
            logic            expReady;
            logic [BITS-1:0] expA;
            logic [BITS-1:0] expB;
            expReady = (clearCount >= REGS);
            expA = '0;
            expB = '0;
            if (expReady) begin
                expA = modelReg[bus.ra_addr_in];
                expB = modelReg[bus.rb_addr_in];
                if (FWD && bus.wr_valid_in && bus.wr_addr_in == bus.ra_addr_in) expA = bus.wr_data_in;
                if (FWD && bus.wr_valid_in && bus.wr_addr_in == bus.rb_addr_in) expB = bus.wr_data_in;
            end
            checkOutput("model_ready", 32'(bus.wr_ready_out), 32'(expReady));
            checkOutput("model_a", 32'(bus.a_out), 32'(expA));
            checkOutput("model_b", 32'(bus.b_out), 32'(expB));
            checkOutput("model_zero", 32'(bus.zero_out), 32'(modelZero));
            checkOutput("model_neg", 32'(bus.neg_out), 32'(modelNeg));
        end
    end

    initial begin
        logic [BITS-1:0] opA;
        logic [BITS-1:0] opB;
        logic [BITS-1:0] res;

        rst_in          = 1'b1;
        bus.wr_valid_in = 1'b0;
        bus.wr_addr_in  = '0;
        bus.wr_data_in  = '0;
        bus.ra_addr_in  = '0;
        bus.rb_addr_in  = '0;

        // Reset held for two cycles.
        applyStimulus(1, 0, 0, 8'h00, 0, 0);
        applyStimulus(1, 0, 0, 8'h00, 0, 0);
        settle();
        checkOutput("rst_ready", 32'(bus.wr_ready_out), 32'd0);
        checkOutput("rst_a", 32'(bus.a_out), 32'd0);
        checkOutput("rst_flags", {30'd0, bus.zero_out, bus.neg_out}, 32'd0);

        // Clear stall: write held from release, ready low for exactly REGS cycles.
        for (int i = 0; i < REGS; i++) begin
            applyStimulus(0, 1, 1, 8'h55, 0, 0);
            settle();
            checkOutput($sformatf("clear_ready_%0d", i), 32'(bus.wr_ready_out), 32'd0);
            checkOutput($sformatf("clear_b_%0d", i), 32'(bus.b_out), 32'd0);
        end
        applyStimulus(0, 1, 1, 8'h55, 0, 0);
        settle();
        checkOutput("first_run_ready", 32'(bus.wr_ready_out), 32'd1);
        applyStimulus(0, 0, 0, 8'h00, 1, 1);
        settle();
        checkOutput("stall_a", 32'(bus.a_out), 32'h55);
        checkOutput("stall_flags", {30'd0, bus.zero_out, bus.neg_out}, 32'd0);

        // Write/flags sequence.
        applyStimulus(0, 1, 2, 8'hA5, 2, 1);
        applyStimulus(0, 1, 1, 8'h00, 2, 1);
        settle();
        checkOutput("wf_neg1", 32'(bus.neg_out), 32'd1);
        checkOutput("wf_zero1", 32'(bus.zero_out), 32'd0);
        checkOutput("wf_a", 32'(bus.a_out), 32'hA5);
        applyStimulus(0, 0, 3, 8'h77, 2, 1);
        settle();
        checkOutput("wf_b", 32'(bus.b_out), 32'h00);
        checkOutput("wf_zero2", 32'(bus.zero_out), 32'd1);
        checkOutput("wf_neg2", 32'(bus.neg_out), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 2, 8'hFF, 2, 1);
        settle();
        checkOutput("wf_hold", {30'd0, bus.zero_out, bus.neg_out}, 32'd2);

        // Same-cycle read/write on r3 (still zero from the clear).
        applyStimulus(0, 1, 3, 8'h3C, 3, 0);
        settle();
        checkOutput("same_cycle_a", 32'(bus.a_out), FWD ? 32'h3C : 32'h00);
        applyStimulus(0, 0, 0, 8'h00, 3, 0);
        settle();
        checkOutput("after_write_a", 32'(bus.a_out), 32'h3C);

        // Mid-run reset discards the pending write and re-clears everything.
        for (int r = 0; r < REGS; r++) applyStimulus(0, 1, ADDR'(r), 8'hFF, 0, 0);
        applyStimulus(1, 1, 0, 8'h12, 0, 0);
        for (int i = 0; i < REGS; i++) applyStimulus(0, 0, 0, 8'h00, 0, 0);
        for (int r = 0; r < REGS; r++) begin
            applyStimulus(0, 0, 0, 8'h00, ADDR'(r), ADDR'(REGS - 1 - r));
            settle();
            checkOutput($sformatf("midrst_r%0d", r), 32'(bus.a_out), 32'd0);
        end
        checkOutput("midrst_flags", {30'd0, bus.zero_out, bus.neg_out}, 32'd0);
        checkOutput("midrst_ready", 32'(bus.wr_ready_out), 32'd1);

        // Closed loop with an AND ula: r0=a, r1=b, r2 <= a_out & b_out.
        for (int k = 0; k < 260; k++) begin
            case (k)
                0: begin opA = 8'h00; opB = 8'hFF; end
                1: begin opA = 8'hFF; opB = 8'hFF; end
                2: begin opA = 8'hAA; opB = 8'h55; end
                3: begin opA = 8'h80; opB = 8'hC0; end
                default: begin opA = 8'($urandom); opB = 8'($urandom); end
            endcase
            applyStimulus(0, 1, 0, opA, 0, 1);
            applyStimulus(0, 1, 1, opB, 0, 1);
            applyStimulus(0, 0, 0, 8'h00, 0, 1);
            #1;
            res = bus.a_out & bus.b_out;
            bus.wr_valid_in = 1'b1;
            bus.wr_addr_in  = 2;
            bus.wr_data_in  = res;
            applyStimulus(0, 0, 0, 8'h00, 2, 2);
            settle();
            checkOutput("loop_and", 32'(bus.a_out), 32'(opA & opB));
            checkOutput("loop_zero", 32'(bus.zero_out), 32'((opA & opB) == 8'h00));
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2500; i++) begin
            applyStimulus(($urandom_range(0, 149) == 0), 1'($urandom), ADDR'($urandom),
                          ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                          ADDR'($urandom), ADDR'($urandom));
        end
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/ula_wb.md
Name: ula_wb

Overview:
- Write-back stage directly downstream of the ula; it also feeds the ula's operands.
- Holds a small register bank. It captures ula result_out into a destination register and drives the ula a_in/b_in operands from two combinational read ports.
- Maintains zero/negative status flags from the last written result.
- After reset it runs a clear sequence that zeroes every register before it accepts writes.

Parameters:
- BITS, 8, data width; matches the ula BITS.
- REGS, 4, number of registers.
- ADDR, 2, register address width; must equal clog2(REGS).

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  reset, synchronous, active-high.
- wr_valid_in  input  1  write request from the execute side.
- wr_ready_out  output  1  stage can accept a write this cycle.
- wr_addr_in  input  ADDR  destination register.
- wr_data_in  input  BITS  write data; connected to ula result_out.
- ra_addr_in  input  ADDR  read port A address.
- rb_addr_in  input  ADDR  read port B address.
- a_out  output  BITS  register[ra_addr_in]; connected to ula a_in.
- b_out  output  BITS  register[rb_addr_in]; connected to ula b_in.
- zero_out  output  1  last accepted write data was zero.
- neg_out  output  1  MSB of last accepted write data.

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_in is synchronous and active-high.
- Reset values, for rst_in sampled high in any state: state=CLEAR, clear counter=0, zero_out=0, neg_out=0, wr_ready_out=0. Any write presented in that cycle is discarded.
- FSM CLEAR:
  - Each cycle writes 0 to reg[counter], then counter+1.
  - When counter==REGS-1 is written, next state=RUN.
  - wr_ready_out=0 throughout; wr_valid_in is ignored and not accepted, so upstream must hold it.
  - a_out and b_out are forced to 0 during CLEAR.
- Clear timing: first cycle with rst_in low is clear cycle 0. wr_ready_out rises at the edge after clear cycle REGS-1, i.e. REGS cycles after reset deasserts.
- FSM RUN:
  - wr_ready_out=1 and stays in RUN until reset; no other exit.
  - A write is accepted on the rising edge when wr_valid_in && wr_ready_out: reg[wr_addr_in] <= wr_data_in.
- Reads: combinational from the register array. A written value is visible on a_out/b_out the cycle after acceptance (1-cycle write-to-read latency).
- Flags:
  - Update only on an accepted write: zero_out <= (wr_data_in==0), neg_out <= wr_data_in[BITS-1].
  - Otherwise hold their value.
  - Flags are registered and valid the cycle after the write.
- Simultaneous read and write to the same address: the read returns the old value unless the optional feature below is compiled in.
- ra_addr_in == rb_addr_in is legal; both outputs return the same register.
- Width rules: no arithmetic on data. The counter is ADDR bits wide and the terminal compare is counter==REGS-1, so wrap is never reached.

Optional Feature:
- Macro: ULA_WB_FORWARD_EN.
- Defined: write-to-read bypass. When wr_valid_in && wr_ready_out && wr_addr_in==ra_addr_in, a_out = wr_data_in combinationally; same rule for b_out with rb_addr_in. The bypass is inactive in CLEAR.
- Undefined: no bypass; same-cycle reads return the stored (old) value.

Decomposition:
- utils.vh holds BITS, REGS, REG_ADDR, and the state encodings WB_CLEAR=1'b0 and WB_RUN=1'b1, alongside the existing ULA_OP and ASSERT.
- Natural sub-module: reg_bank, containing the storage array, one write port and two combinational read ports.
- ula_wb keeps the FSM, clear counter, handshake, flags and forwarding mux.

Test Plan:
- Reset: hold rst_in 2 cycles, release. wr_ready_out=0 for exactly 4 cycles, then 1. a_out=b_out=0, zero_out=neg_out=0 throughout.
- Clear stall: wr_valid_in=1, wr_addr_in=1, wr_data_in=0x55 from the reset release onward. The write is accepted only on the first RUN cycle. Next cycle ra_addr_in=1 gives a_out=0x55, zero_out=0, neg_out=0.
- Write/flags: write 0xA5 to r2, then 0x00 to r1. With ra=2, rb=1: a_out=0xA5, b_out=0x00. Flags after first write: neg_out=1, zero_out=0. Flags after second write: zero_out=1, neg_out=0. Flags hold while wr_valid_in=0.
- Same-cycle read: r3=0x00, write 0x3C to r3 with ra_addr_in=3. That cycle a_out=0x00 without ULA_WB_FORWARD_EN, 0x3C with it. Next cycle a_out=0x3C in both builds.
- Mid-run reset: after writing 0xFF to all registers, pulse rst_in for 1 cycle while wr_valid_in=1. The pending write is discarded; after 4 clear cycles every register reads 0x00 and flags are 0.
- Closed loop with ula, ula_op=1 (and): for all 256×256 a/b pairs, preload r0=a and r1=b, read via ra=0, rb=1, write the result to r2. Check with ASSERT that r2 equals a & b and zero_out == ((a & b) == 0).
